// File: rtl/chain_code_sequencer_pkg.sv
// Shared types and constants for the chain-code contour sequencer.
package chain_code_sequencer_pkg;

    localparam int unsigned PERIM_W   = 9;
    localparam int unsigned CODE_W    = 3;
    localparam int unsigned ERR_W     = 2;
    localparam int unsigned GRID_SIZE = 64;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_ISSUE  = 3'd3,
        S_CHECK  = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    localparam logic [ERR_W-1:0] ERR_NONE  = 2'b00;
    localparam logic [ERR_W-1:0] ERR_OOB   = 2'b01;
    localparam logic [ERR_W-1:0] ERR_OPEN  = 2'b10;
    localparam logic [ERR_W-1:0] ERR_EMPTY = 2'b11;

    // Chain-code directions, named by the (x,y) step they produce
    localparam logic [CODE_W-1:0] DIR_YP    = 3'd0;
    localparam logic [CODE_W-1:0] DIR_XM_YP = 3'd1;
    localparam logic [CODE_W-1:0] DIR_XM    = 3'd2;
    localparam logic [CODE_W-1:0] DIR_XM_YM = 3'd3;
    localparam logic [CODE_W-1:0] DIR_YM    = 3'd4;
    localparam logic [CODE_W-1:0] DIR_XP_YM = 3'd5;
    localparam logic [CODE_W-1:0] DIR_XP    = 3'd6;
    localparam logic [CODE_W-1:0] DIR_XP_YP = 3'd7;

endpackage

// File: rtl/chain_code_step.sv
// Combinational direction-to-step lookup with grid range check.
module chain_code_step
    import chain_code_sequencer_pkg::*;
#(
    parameter int unsigned COORD_W = 6
) (
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [CODE_W-1:0]  i_code,
    output logic [COORD_W-1:0] o_x_c,
    output logic [COORD_W-1:0] o_y_c,
    output logic               o_oob_c
);

    localparam int unsigned SW = COORD_W + 1;
    localparam logic signed [SW-1:0] STEP_P = SW'(1);
    localparam logic signed [SW-1:0] STEP_M = -STEP_P;

    logic signed [SW-1:0] w_dx;
    logic signed [SW-1:0] w_dy;
    logic signed [SW-1:0] w_nx;
    logic signed [SW-1:0] w_ny;

    always_comb begin
        w_dx = '0;
        w_dy = '0;
        case (i_code)
            DIR_YP:    begin w_dy = STEP_P; end
            DIR_XM_YP: begin w_dx = STEP_M; w_dy = STEP_P; end
            DIR_XM:    begin w_dx = STEP_M; end
            DIR_XM_YM: begin w_dx = STEP_M; w_dy = STEP_M; end
            DIR_YM:    begin w_dy = STEP_M; end
            DIR_XP_YM: begin w_dx = STEP_P; w_dy = STEP_M; end
            DIR_XP:    begin w_dx = STEP_P; end
            DIR_XP_YP: begin w_dx = STEP_P; w_dy = STEP_P; end
            default:   begin w_dx = '0; w_dy = '0; end
        endcase
    end

    assign w_nx = $signed({1'b0, i_x}) + w_dx;
    assign w_ny = $signed({1'b0, i_y}) + w_dy;

    // The grid spans exactly 2^COORD_W, so both -1 and 2^COORD_W land with the sign bit set
    assign o_oob_c = w_nx[SW-1] | w_ny[SW-1];
    assign o_x_c   = w_nx[COORD_W-1:0];
    assign o_y_c   = w_ny[COORD_W-1:0];

endmodule

// File: rtl/chain_code_sequencer.sv
// Fetches one contour's chain codes, streams them to the decoder and traces
// the resulting position, flagging empty, out-of-grid and unclosed contours.
module chain_code_sequencer
    import chain_code_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned COORD_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_start,
    input  logic [COORD_W-1:0] cmd_start_x,
    input  logic [COORD_W-1:0] cmd_start_y,
    input  logic [PERIM_W-1:0] cmd_perimeter,
    input  logic [ADDR_W-1:0]  cmd_base_addr,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [CODE_W-1:0]  mem_rd_data,
    output logic               dec_valid,
    output logic [CODE_W-1:0]  dec_code,
    input  logic               dec_ready,
    output logic [COORD_W-1:0] cur_x,
    output logic [COORD_W-1:0] cur_y,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [ERR_W-1:0]   err_code
);

    state_t r_state;
    state_t w_state_nxt;

    logic [COORD_W-1:0] r_start_x;
    logic [COORD_W-1:0] r_start_y;
    logic [PERIM_W-1:0] r_perim;
    logic [ADDR_W-1:0]  r_base;
    logic [PERIM_W-1:0] r_idx;
    logic [COORD_W-1:0] r_cur_x;
    logic [COORD_W-1:0] r_cur_y;
    logic [CODE_W-1:0]  r_dec_code;
    logic               r_mem_rd_en;
    logic [ADDR_W-1:0]  r_mem_rd_addr;
    logic               r_dec_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic [ERR_W-1:0]   r_err_code;

    logic [COORD_W-1:0] w_step_x;
    logic [COORD_W-1:0] w_step_y;
    logic               w_oob;
    logic [PERIM_W-1:0] w_idx_inc;
    logic               w_last;
    logic [PERIM_W-1:0] w_fetch_idx;
    logic [ADDR_W-1:0]  w_fetch_base;

    chain_code_step #(
        .COORD_W (COORD_W)
    ) u_step (
        .i_x     (r_cur_x),
        .i_y     (r_cur_y),
        .i_code  (r_dec_code),
        .o_x_c   (w_step_x),
        .o_y_c   (w_step_y),
        .o_oob_c (w_oob)
    );

    assign w_idx_inc = r_idx + PERIM_W'(1);
    assign w_last    = (w_idx_inc == r_perim);

    // Entering FETCH from IDLE uses the incoming command; from ISSUE, the next index
    assign w_fetch_idx  = (r_state == S_IDLE) ? '0 : w_idx_inc;
    assign w_fetch_base = (r_state == S_IDLE) ? cmd_base_addr : r_base;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_start) begin
                    w_state_nxt = (cmd_perimeter == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH:  w_state_nxt = S_LOAD;
            S_LOAD:   w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (dec_ready) begin
                    if (w_oob) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_state_nxt = w_last ? S_CHECK : S_FETCH;
                    end
                end
            end
            S_CHECK:  w_state_nxt = S_FINISH;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Status strobes are registered from the next state so they align with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_x     <= '0;
            r_start_y     <= '0;
            r_perim       <= '0;
            r_base        <= '0;
            r_idx         <= '0;
            r_cur_x       <= '0;
            r_cur_y       <= '0;
            r_dec_code    <= '0;
            r_mem_rd_en   <= 1'b0;
            r_mem_rd_addr <= '0;
            r_dec_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_err_code    <= ERR_NONE;
        end else begin
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_FINISH);
            r_mem_rd_en <= (w_state_nxt == S_FETCH);
            r_dec_valid <= (w_state_nxt == S_ISSUE);
            if (w_state_nxt == S_FETCH) begin
                r_mem_rd_addr <= w_fetch_base + ADDR_W'(w_fetch_idx);
            end
            case (r_state)
                S_IDLE: begin
                    if (cmd_start) begin
                        r_start_x  <= cmd_start_x;
                        r_start_y  <= cmd_start_y;
                        r_perim    <= cmd_perimeter;
                        r_base     <= cmd_base_addr;
                        r_cur_x    <= cmd_start_x;
                        r_cur_y    <= cmd_start_y;
                        r_idx      <= '0;
                        r_error    <= (cmd_perimeter == '0);
                        r_err_code <= (cmd_perimeter == '0) ? ERR_EMPTY : ERR_NONE;
                    end
                end
                S_LOAD: r_dec_code <= mem_rd_data;
                S_ISSUE: begin
                    if (dec_ready) begin
                        if (w_oob) begin
                            r_error    <= 1'b1;
                            r_err_code <= ERR_OOB;
                        end else begin
                            r_cur_x <= w_step_x;
                            r_cur_y <= w_step_y;
                            r_idx   <= w_idx_inc;
                        end
                    end
                end
                S_CHECK: begin
                    if ((r_cur_x != r_start_x) || (r_cur_y != r_start_y)) begin
                        r_error    <= 1'b1;
                        r_err_code <= ERR_OPEN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_rd_en   = r_mem_rd_en;
    assign mem_rd_addr = r_mem_rd_addr;
    assign dec_valid   = r_dec_valid;
    assign dec_code    = r_dec_code;
    assign cur_x       = r_cur_x;
    assign cur_y       = r_cur_y;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign err_code    = r_err_code;

endmodule

// File: doc/chain_code_sequencer.md
CHAIN_CODE_SEQUENCER -- requirements
Module: chain_code_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning code-memory address width.
REQ-002 SHALL have parameter COORD_W, default 6, meaning pixel coordinate width on a 64x64 grid.
REQ-003 SHALL have clk  input  1  clock; all logic is rising-edge.
REQ-004 SHALL have reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have cmd_start  input  1  one-cycle request to trace one contour.
REQ-006 SHALL have cmd_start_x, cmd_start_y  input  COORD_W each  contour start row and column.
REQ-007 SHALL have cmd_perimeter  input  9  number of chain codes in the contour.
REQ-008 SHALL have cmd_base_addr  input  ADDR_W  address of the first code.
REQ-009 SHALL have mem_rd_en  output  1 and mem_rd_addr  output  ADDR_W  code-memory read request.
REQ-010 SHALL have mem_rd_data  input  3  code, valid exactly one cycle after mem_rd_en.
REQ-011 SHALL have dec_valid  output  1, dec_code  output  3, dec_ready  input  1  valid/ready code stream to the decoder datapath.
REQ-012 SHALL have cur_x, cur_y  output  COORD_W each  current traced position.
REQ-013 SHALL have busy  output  1, done  output  1, error  output  1, err_code  output  2  status.

Function
REQ-014 SHALL implement the states IDLE, FETCH, LOAD, ISSUE, CHECK and FINISH.
REQ-015 In IDLE, cmd_start SHALL latch all cmd_* inputs, set cur_x/cur_y to start, clear idx, error and err_code, and go to FETCH; busy SHALL be 1 in every state except IDLE.
REQ-016 cmd_start with cmd_perimeter==0 SHALL go directly to FINISH with error=1, err_code=2'b11.
REQ-017 FETCH SHALL assert mem_rd_en for one cycle with mem_rd_addr = base + idx (modulo 2^ADDR_W) and go to LOAD.
REQ-018 LOAD SHALL register mem_rd_data into dec_code and go to ISSUE.
REQ-019 ISSUE SHALL hold dec_valid=1 with dec_code stable until dec_ready=1; dec_valid SHALL be 0 in all other states.
REQ-020 On handshake, cur_x/cur_y SHALL step as follows: code 0: y+1; 1: x-1,y+1; 2: x-1; 3: x-1,y-1; 4: y-1; 5: x+1,y-1; 6: x+1; 7: x+1,y+1.
REQ-021 The step SHALL be computed at COORD_W+1 bits, signed; a result outside 0..63 SHALL leave the position unchanged, set error=1, err_code=2'b01, and go to FINISH.
REQ-022 After an in-range handshake, idx SHALL increment; if idx+1 == perimeter the FSM SHALL go to CHECK, otherwise to FETCH.
REQ-023 CHECK SHALL compare the position to the start; on mismatch it SHALL set error=1, err_code=2'b10. In both cases it SHALL go to FINISH.
REQ-024 FINISH SHALL pulse done for exactly one cycle and return to IDLE; error and err_code SHALL hold until the next accepted cmd_start.
REQ-025 cmd_start while busy SHALL be ignored.
REQ-026 Each code SHALL take a minimum of 3 cycles (FETCH, LOAD, ISSUE); a contour of P codes with dec_ready tied to 1 SHALL assert done exactly 3P+2 cycles after cmd_start is accepted.
REQ-027 err_code SHALL be 2'b00 when there is no error.

Reset
REQ-028 reset SHALL force IDLE and drive busy, done, error, dec_valid and mem_rd_en to 0, err_code, dec_code, cur_x, cur_y, idx and mem_rd_addr to 0; reset mid-contour SHALL abandon the contour without asserting done.

Structure
REQ-029 A shared package SHALL hold the state encoding, the err_code constants (NONE=0, OOB=1, OPEN=2, EMPTY=3), the chain-code direction constants and the 64-pixel grid size.
REQ-030 The direction-to-step lookup with range check SHALL be a sub-module named chain_code_step.

Verification
REQ-031 Start (10,10), perimeter 4, codes 0,6,4,2, dec_ready=1 -> positions (10,11),(11,11),(11,10),(10,10); done at cycle 14; error=0.
REQ-032 Start (10,10), perimeter 3, codes 0,0,6 -> done, error=1, err_code=2'b10, final position (11,12).
REQ-033 Start (0,5), code 2 -> error=1, err_code=2'b01, position stays (0,5), done after one handshake.
REQ-034 cmd_perimeter=0 -> done on the cycle after cmd_start, err_code=2'b11, no mem_rd_en.
REQ-035 Square contour from REQ-031 with dec_ready low for 5 cycles on code 2 -> dec_valid and dec_code stay stable, done is delayed by 5 cycles, and a cmd_start issued while busy is ignored.
REQ-036 Assert reset during the third ISSUE -> all outputs go to zero at once, no done pulse, and a new cmd_start afterwards traces normally.
